// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the alu_arbiter slice.
package alu_arb_pkg;

   localparam int ALU_CTRL_W = 4;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'b0011;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA = 4'b0100;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0101;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 4'b0111;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: grants the first request at or after ptr, with wrap.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic [ID_W-1:0]    ptr
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      if (en) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               grant_idx  = ID_W'(idx);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (|grant) begin
         ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between NUM_REQ requesters; one-entry response register.
// Optional perf counters (grant_cnt, stall_cnt) when ALU_ARB_PERF_EN is defined.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 64,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]    req_a,
   input  logic [NUM_REQ*DATA_W-1:0]    req_b,
   input  logic [NUM_REQ*ALU_CTRL_W-1:0] req_ctrl,
   output logic [DATA_W-1:0]            alu_a,
   output logic [DATA_W-1:0]            alu_b,
   output logic [ALU_CTRL_W-1:0]        alu_control,
   input  logic [DATA_W-1:0]            alu_result,
   input  logic                         alu_zero,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [ID_W-1:0]              rsp_id,
   output logic [DATA_W-1:0]            rsp_result,
   output logic                         rsp_zero
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [NUM_REQ*32-1:0]        grant_cnt,
   output logic [31:0]                  stall_cnt
`endif
);

   rsp_state_t         state, state_nxt;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    sel;
   logic               can_issue;
   logic               granted;

   assign rsp_valid = (state == RSP_FULL);
   assign can_issue = !rsp_valid || rsp_ready;
   assign granted   = |grant;
   assign req_ready = grant;

   // Gating with rst keeps req_ready low while reset is held.
   rr_arbiter #(
      .NUM_REQ(NUM_REQ),
      .ID_W   (ID_W)
   ) u_rr (
      .clk      (clk),
      .rst      (rst),
      .req      (req_valid),
      .en       (can_issue && !rst),
      .grant    (grant),
      .grant_idx(grant_idx),
      .ptr      (ptr)
   );

   assign sel         = granted ? grant_idx : ptr;
   assign alu_a       = req_a[sel*DATA_W +: DATA_W];
   assign alu_b       = req_b[sel*DATA_W +: DATA_W];
   assign alu_control = granted ? req_ctrl[sel*ALU_CTRL_W +: ALU_CTRL_W] : ALU_ADD;

   always_ff @(posedge clk) begin
      if (rst) state <= RSP_EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RSP_EMPTY: if (granted) state_nxt = RSP_FULL;
         RSP_FULL:  if (!granted && rsp_ready) state_nxt = RSP_EMPTY;
         default:   state_nxt = RSP_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else if (granted) begin
         rsp_id     <= grant_idx;
         rsp_result <= alu_result;
         rsp_zero   <= alu_zero;
      end
   end

`ifdef ALU_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
         end
         if (rsp_valid && !rsp_ready) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`else
   // No perf counters in this build.
`endif

endmodule
